// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM fetch arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  typedef enum logic {
    REQ_M68K,
    REQ_Z80
  } req_t;

  localparam logic [31:0] ROM2_OFFSET   = 32'h0004_0000;
  localparam logic [31:0] BANKED_OFFSET = 32'h0001_0000;
  localparam logic [31:0] BANK_STRIDE   = 32'h0000_4000;

endpackage

// File: rtl/rom_arb_xlate.sv
// CPU-window to flat ROM byte address translation, one instance per requester.
module rom_arb_xlate
  import rom_arb_pkg::*;
#(
  parameter int unsigned       ROM_AW = 24,
  parameter logic [ROM_AW-1:0] BASE   = '0,
  parameter bit                IS_Z80 = 1'b0
) (
  input  logic              alt_cs,
  input  logic [22:0]       addr,
  input  logic [4:0]        bank,
  output logic [ROM_AW-1:0] flat
);

  logic [31:0] m68k_off;
  logic [31:0] z80_off;
  logic        unused_hi;

  assign unused_hi = ^addr[22:17];

  always_comb begin
    m68k_off = {14'd0, addr[16:0], 1'b0};
    if (alt_cs) m68k_off = m68k_off + ROM2_OFFSET;

    if (alt_cs) z80_off = BANKED_OFFSET + 32'(bank) * BANK_STRIDE + {18'd0, addr[13:1], 1'b0};
    else        z80_off = {17'd0, addr[14:1], 1'b0};

    // Wrap-around comes from truncating to ROM_AW; bit0 is forced even for odd BASE.
    flat    = BASE + ROM_AW'(IS_Z80 ? z80_off : m68k_off);
    flat[0] = 1'b0;
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin sharing of one 16-bit ROM port between 68k program and Z80 sound fetches.
// Optional one-entry per-requester hit cache: define ROM_HIT_CACHE_EN.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned       ROM_AW    = 24,
  parameter logic [ROM_AW-1:0] M68K_BASE = 24'h000000,
  parameter logic [ROM_AW-1:0] Z80_BASE  = 24'h080000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m68k_rom_cs,
  input  logic              m68k_rom_2_cs,
  input  logic [22:0]       m68k_a,
  output logic [15:0]       m68k_dout,
  output logic              m68k_ready,
  input  logic              z80_rom_cs,
  input  logic              z80_banked_cs,
  input  logic [15:0]       z80_addr,
  input  logic [4:0]        z80_bank,
  output logic [7:0]        z80_dout,
  output logic              z80_ready,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data
);

  state_t            state, state_next;
  req_t              grant, grant_next, last_served;
  logic [ROM_AW-1:0] flat_m, flat_z, addr_next;
  logic              active_m, active_z, pending_m, pending_z;
  logic              served_m, served_z;
  logic              grant_active, abort, fetch_keep, capture;
  logic              req_next, hit_path, hit_next;
  logic              take_hit_m, take_hit_z;
  logic [15:0]       hit_word_m, hit_word_z;

  rom_arb_xlate #(.ROM_AW(ROM_AW), .BASE(M68K_BASE), .IS_Z80(1'b0)) u_xlate_m68k (
    .alt_cs (m68k_rom_2_cs & ~m68k_rom_cs),
    .addr   (m68k_a),
    .bank   (5'd0),
    .flat   (flat_m)
  );

  rom_arb_xlate #(.ROM_AW(ROM_AW), .BASE(Z80_BASE), .IS_Z80(1'b1)) u_xlate_z80 (
    .alt_cs (z80_banked_cs & ~z80_rom_cs),
    .addr   ({7'd0, z80_addr}),
    .bank   (z80_bank),
    .flat   (flat_z)
  );

  assign active_m     = m68k_rom_cs | m68k_rom_2_cs;
  assign active_z     = z80_rom_cs | z80_banked_cs;
  assign pending_m    = active_m & ~served_m;
  assign pending_z    = active_z & ~served_z;
  assign grant_active = (grant == REQ_M68K) ? active_m : active_z;
  // A cs drop at any point of the fetch voids it, even if cs has come back by ack time.
  assign fetch_keep   = ~abort & grant_active;
  assign capture      = (state == FETCH) & rom_ack & fetch_keep;

  assign m68k_ready = (state == DONE) && (grant == REQ_M68K) && active_m;
  assign z80_ready  = (state == DONE) && (grant == REQ_Z80) && active_z;

`ifdef ROM_HIT_CACHE_EN
  logic              cval_m, cval_z;
  logic [ROM_AW-1:0] ctag_m, ctag_z;
  logic [15:0]       cdat_m, cdat_z;
  logic [4:0]        bank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cval_m <= 1'b0;
      cval_z <= 1'b0;
      ctag_m <= '0;
      ctag_z <= '0;
      cdat_m <= '0;
      cdat_z <= '0;
      bank_q <= '0;
    end else begin
      bank_q <= z80_bank;
      if (capture && grant == REQ_M68K) begin
        cval_m <= 1'b1;
        ctag_m <= rom_addr;
        cdat_m <= rom_data;
      end
      if (capture && grant == REQ_Z80) begin
        cval_z <= 1'b1;
        ctag_z <= rom_addr;
        cdat_z <= rom_data;
      end
      if (z80_bank != bank_q) cval_z <= 1'b0;
    end
  end

  assign take_hit_m = (state == IDLE) && pending_m && cval_m && (ctag_m == flat_m);
  assign take_hit_z = (state == IDLE) && pending_z && cval_z && (ctag_z == flat_z) && !take_hit_m;
  assign hit_word_m = cdat_m;
  assign hit_word_z = cdat_z;
`else
  assign take_hit_m = 1'b0;
  assign take_hit_z = 1'b0;
  assign hit_word_m = '0;
  assign hit_word_z = '0;
`endif

  always_comb begin
    state_next = state;
    grant_next = grant;
    addr_next  = rom_addr;
    req_next   = rom_req;
    hit_next   = 1'b0;
    case (state)
      IDLE: begin
        if (take_hit_m || take_hit_z) begin
          grant_next = take_hit_m ? REQ_M68K : REQ_Z80;
          hit_next   = 1'b1;
          state_next = DONE;
        end else if (pending_m || pending_z) begin
          if (pending_m && pending_z) grant_next = (last_served == REQ_M68K) ? REQ_Z80 : REQ_M68K;
          else                        grant_next = pending_m ? REQ_M68K : REQ_Z80;
          addr_next  = (grant_next == REQ_M68K) ? flat_m : flat_z;
          req_next   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (rom_ack) begin
          req_next   = 1'b0;
          state_next = fetch_keep ? DONE : IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= REQ_M68K;
      last_served <= REQ_M68K;
      rom_req     <= 1'b0;
      rom_addr    <= '0;
      m68k_dout   <= '0;
      z80_dout    <= '0;
      served_m    <= 1'b0;
      served_z    <= 1'b0;
      abort       <= 1'b0;
      hit_path    <= 1'b0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      rom_req  <= req_next;
      rom_addr <= addr_next;
      hit_path <= hit_next;
      abort    <= (state == FETCH) && (abort || !grant_active);

      if (capture && grant == REQ_M68K) m68k_dout <= rom_data;
      else if (take_hit_m)              m68k_dout <= hit_word_m;

      if (capture && grant == REQ_Z80) z80_dout <= z80_addr[0] ? rom_data[15:8] : rom_data[7:0];
      else if (take_hit_z)             z80_dout <= z80_addr[0] ? hit_word_z[15:8] : hit_word_z[7:0];

      if (!active_m)       served_m <= 1'b0;
      else if (m68k_ready) served_m <= 1'b1;
      if (!active_z)       served_z <= 1'b0;
      else if (z80_ready)  served_z <= 1'b1;

      if (state == DONE && !hit_path) last_served <= grant;
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios plus randomized traffic.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m68k_rom_cs, m68k_rom_2_cs;
  logic [22:0] m68k_a;
  logic [15:0] m68k_dout;
  logic        m68k_ready;
  logic        z80_rom_cs, z80_banked_cs;
  logic [15:0] z80_addr;
  logic [4:0]  z80_bank;
  logic [7:0]  z80_dout;
  logic        z80_ready;
  logic [23:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;

  int   total = 0;
  int   bad   = 0;
  bit   last_srv;           // 0 = 68k served last, 1 = Z80
  logic [15:0] exp_mdout;
  logic [7:0]  exp_zdout;

  always #5 clk = ~clk;

  rom_fetch_arbiter #(
    .ROM_AW    (24),
    .M68K_BASE (24'h000000),
    .Z80_BASE  (24'h080000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m68k_rom_cs   (m68k_rom_cs),
    .m68k_rom_2_cs (m68k_rom_2_cs),
    .m68k_a        (m68k_a),
    .m68k_dout     (m68k_dout),
    .m68k_ready    (m68k_ready),
    .z80_rom_cs    (z80_rom_cs),
    .z80_banked_cs (z80_banked_cs),
    .z80_addr      (z80_addr),
    .z80_bank      (z80_bank),
    .z80_dout      (z80_dout),
    .z80_ready     (z80_ready),
    .rom_addr      (rom_addr),
    .rom_req       (rom_req),
    .rom_ack       (rom_ack),
    .rom_data      (rom_data)
  );

  function automatic logic [23:0] m68k_flat(input bit alt, input logic [22:0] a);
    int unsigned b;
    b = (32'(a) % 32'h20000) * 2;
    if (alt) b = b + 32'h40000;
    return 24'(b);
  endfunction

  function automatic logic [23:0] z80_flat(input bit banked, input logic [15:0] za, input logic [4:0] bk);
    int unsigned b;
    if (banked) b = 32'h80000 + 32'h10000 + 32'(bk) * 32'h4000 + (32'(za) % 32'h4000) / 2 * 2;
    else        b = 32'h80000 + (32'(za) % 32'h8000) / 2 * 2;
    return 24'(b);
  endfunction

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    logic [31:0] x;
    x = {8'd0, a} * 32'd2654435761;
    return x[31:16] ^ x[15:0];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m68k_rom_cs = 0; m68k_rom_2_cs = 0; m68k_a = '0;
    z80_rom_cs = 0; z80_banked_cs = 0; z80_addr = '0; z80_bank = '0;
    rom_ack = 0; rom_data = '0;
    tick(); tick(); tick();
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", rom_req); end
    total++; if (rom_addr !== 24'h0) begin bad++; $display("FAIL rst_addr: got %h want 000000", rom_addr); end
    total++; if (m68k_ready !== 1'b0 || z80_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b%b want 00", m68k_ready, z80_ready); end
    total++; if (m68k_dout !== 16'h0) begin bad++; $display("FAIL rst_mdout: got %h want 0000", m68k_dout); end
    total++; if (z80_dout !== 8'h0) begin bad++; $display("FAIL rst_zdout: got %h want 00", z80_dout); end
    reset = 1'b0;
    tick();
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", rom_req); end
    last_srv = 0; exp_mdout = '0; exp_zdout = '0;
  endtask

  task automatic test_tie(input logic [22:0] a, input logic [15:0] za);
    bit          first_z, this_z;
    logic [23:0] em, ez;
    logic [15:0] wd;
    first_z = (last_srv == 0);
    em = m68k_flat(0, a);
    ez = z80_flat(0, za, 5'd0);
    m68k_a = a; z80_addr = za;
    m68k_rom_cs = 1; z80_rom_cs = 1;
    for (int k = 0; k < 2; k++) begin
      this_z = (k == 0) ? first_z : !first_z;
      for (int i = 0; i < 20 && rom_req !== 1'b1; i++) tick();
      total++; if (rom_req !== 1'b1) begin bad++; $display("FAIL tie_req%0d: got %b want 1", k, rom_req); end
      total++; if (rom_addr !== (this_z ? ez : em)) begin bad++; $display("FAIL tie_order%0d: got %h want %h", k, rom_addr, this_z ? ez : em); end
      wd = this_z ? 16'h5AA5 : 16'hC0DE;
      rom_data = wd; rom_ack = 1;
      tick();
      rom_ack = 0; rom_data = 16'($urandom);
      if (this_z) begin
        exp_zdout = za[0] ? wd[15:8] : wd[7:0];
        total++; if (z80_ready !== 1'b1 || m68k_ready !== 1'b0 || z80_dout !== exp_zdout) begin
          bad++; $display("FAIL tie_zdone%0d: got rdy=%b%b dout=%h want rdy=01 dout=%h", k, m68k_ready, z80_ready, z80_dout, exp_zdout);
        end
        z80_rom_cs = 0; last_srv = 1;
      end else begin
        exp_mdout = wd;
        total++; if (m68k_ready !== 1'b1 || z80_ready !== 1'b0 || m68k_dout !== exp_mdout) begin
          bad++; $display("FAIL tie_mdone%0d: got rdy=%b%b dout=%h want rdy=10 dout=%h", k, m68k_ready, z80_ready, m68k_dout, exp_mdout);
        end
        m68k_rom_cs = 0; last_srv = 0;
      end
    end
    tick(); tick();
  endtask

  task automatic test_m68k_single();
    m68k_a = 23'h000100; m68k_rom_cs = 1;
    tick();
    total++; if (rom_req !== 1'b1 || rom_addr !== 24'h000200) begin bad++; $display("FAIL m_first: got req=%b addr=%h want req=1 addr=000200", rom_req, rom_addr); end
    tick(); tick();
    total++; if (rom_req !== 1'b1 || rom_addr !== 24'h000200 || m68k_ready !== 1'b0) begin bad++; $display("FAIL m_hold: got req=%b addr=%h rdy=%b want 1 000200 0", rom_req, rom_addr, m68k_ready); end
    rom_ack = 1; rom_data = 16'hBEEF;
    tick();
    rom_ack = 0; rom_data = 16'h1111;
    total++; if (m68k_ready !== 1'b1 || m68k_dout !== 16'hBEEF || rom_req !== 1'b0) begin bad++; $display("FAIL m_done: got rdy=%b dout=%h req=%b want 1 beef 0", m68k_ready, m68k_dout, rom_req); end
    m68k_rom_cs = 0;
    tick();
    total++; if (m68k_ready !== 1'b0 || m68k_dout !== 16'hBEEF) begin bad++; $display("FAIL m_pulse: got rdy=%b dout=%h want 0 beef", m68k_ready, m68k_dout); end
    exp_mdout = 16'hBEEF; last_srv = 0;
    tick();
  endtask

  task automatic test_z80_banked();
    z80_bank = 5'd3; z80_addr = 16'hC005; z80_banked_cs = 1;
    tick();
    total++; if (rom_req !== 1'b1 || rom_addr !== 24'h09C004) begin bad++; $display("FAIL z_addr: got req=%b addr=%h want req=1 addr=09c004", rom_req, rom_addr); end
    rom_ack = 1; rom_data = 16'h1234;
    tick();
    rom_ack = 0; rom_data = 16'hEEEE;
    total++; if (z80_ready !== 1'b1 || z80_dout !== 8'h12) begin bad++; $display("FAIL z_done: got rdy=%b dout=%h want 1 12", z80_ready, z80_dout); end
    z80_banked_cs = 0;
    tick();
    total++; if (z80_ready !== 1'b0) begin bad++; $display("FAIL z_pulse: got %b want 0", z80_ready); end
    exp_zdout = 8'h12; last_srv = 1;
    tick();
  endtask

  task automatic test_abort();
    bit seen;
    m68k_a = 23'h002000; m68k_rom_cs = 1;
    tick();
    total++; if (rom_req !== 1'b1 || rom_addr !== 24'h004000) begin bad++; $display("FAIL ab_req: got req=%b addr=%h want 1 004000", rom_req, rom_addr); end
    m68k_rom_cs = 0;
    tick(); tick();
    rom_ack = 1; rom_data = 16'hDEAD;
    tick();
    rom_ack = 0;
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL ab_reqdrop: got %b want 0", rom_req); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (m68k_ready !== 1'b0) seen = 1;
      tick();
    end
    total++; if (seen || m68k_dout !== exp_mdout) begin bad++; $display("FAIL ab_discard: got rdy_seen=%b dout=%h want 0 %h", seen, m68k_dout, exp_mdout); end
    m68k_rom_cs = 1;
    for (int i = 0; i < 10 && rom_req !== 1'b1; i++) tick();
    total++; if (rom_req !== 1'b1 || rom_addr !== 24'h004000) begin bad++; $display("FAIL ab_refetch: got req=%b addr=%h want 1 004000", rom_req, rom_addr); end
    rom_ack = 1; rom_data = 16'h7777;
    tick();
    rom_ack = 0;
    total++; if (m68k_ready !== 1'b1 || m68k_dout !== 16'h7777) begin bad++; $display("FAIL ab_done: got rdy=%b dout=%h want 1 7777", m68k_ready, m68k_dout); end
    m68k_rom_cs = 0; exp_mdout = 16'h7777; last_srv = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_fetch();
    z80_addr = 16'h0042; z80_rom_cs = 1;
    tick();
    total++; if (rom_req !== 1'b1) begin bad++; $display("FAIL rmf_req: got %b want 1", rom_req); end
    reset = 1; z80_rom_cs = 0;
    tick();
    total++; if (rom_req !== 1'b0 || rom_addr !== 24'h0) begin bad++; $display("FAIL rmf_port: got req=%b addr=%h want 0 000000", rom_req, rom_addr); end
    total++; if (m68k_ready !== 1'b0 || z80_ready !== 1'b0 || m68k_dout !== 16'h0 || z80_dout !== 8'h0) begin
      bad++; $display("FAIL rmf_out: got rdy=%b%b mdout=%h zdout=%h want 00 0000 00", m68k_ready, z80_ready, m68k_dout, z80_dout);
    end
    reset = 0;
    rom_ack = 1; rom_data = 16'hFFFF;
    tick();
    rom_ack = 0;
    tick();
    total++; if (rom_req !== 1'b0 || z80_ready !== 1'b0 || z80_dout !== 8'h0) begin bad++; $display("FAIL rmf_stray_ack: got req=%b rdy=%b dout=%h want 0 0 00", rom_req, z80_ready, z80_dout); end
    last_srv = 0; exp_mdout = '0; exp_zdout = '0;
  endtask

  task automatic test_random();
    int          kind, nreq, fidx, sidx, delay;
    bit          wm, wz, alt_m, alt_z, want;
    bit          ord[2];
    logic [22:0] a;
    logic [15:0] za, wd;
    logic [4:0]  bk;
    logic [23:0] em, ez, cur;
    for (int it = 0; it < 60; it++) begin
      kind  = $urandom_range(0, 2);
      wm    = (kind != 1);
      wz    = (kind != 0);
      alt_m = 1'($urandom_range(0, 1));
      alt_z = 1'($urandom_range(0, 1));
      a     = 23'($urandom_range(0, 32'h1FFFF));
      if (alt_m) a = a | 23'h400000;
      za    = alt_z ? (16'hC000 | 16'($urandom_range(0, 32'h3FFF))) : 16'($urandom_range(0, 32'h7FFF));
      bk    = 5'($urandom_range(0, 31));
      em    = m68k_flat(alt_m, a);
      ez    = z80_flat(alt_z, za, bk);
      if (wm && wz) begin ord[0] = (last_srv == 0); ord[1] = !ord[0]; nreq = 2; end
      else begin ord[0] = wz; ord[1] = 0; nreq = 1; end
      m68k_a = a; z80_addr = za; z80_bank = bk;
      m68k_rom_cs = wm && !alt_m; m68k_rom_2_cs = wm && alt_m;
      z80_rom_cs  = wz && !alt_z; z80_banked_cs = wz && alt_z;
      fidx = 0; sidx = 0; delay = -1; cur = '0;
      for (int cyc = 0; cyc < 100 && sidx < nreq; cyc++) begin
        tick();
        rom_ack = 0; rom_data = 16'($urandom);
        if (m68k_ready === 1'b1) begin
          want = (sidx < nreq) && (ord[sidx] == 0);
          exp_mdout = mem_word(em);
          total++; if (!want || m68k_dout !== exp_mdout) begin bad++; $display("FAIL rnd_m%0d: got expected=%b dout=%h want 1 %h", it, want, m68k_dout, exp_mdout); end
          last_srv = 0; sidx++; m68k_rom_cs = 0; m68k_rom_2_cs = 0;
        end
        if (z80_ready === 1'b1) begin
          want = (sidx < nreq) && (ord[sidx] == 1);
          wd = mem_word(ez);
          exp_zdout = za[0] ? wd[15:8] : wd[7:0];
          total++; if (!want || z80_dout !== exp_zdout) begin bad++; $display("FAIL rnd_z%0d: got expected=%b dout=%h want 1 %h", it, want, z80_dout, exp_zdout); end
          last_srv = 1; sidx++; z80_rom_cs = 0; z80_banked_cs = 0;
        end
        if (rom_req === 1'b1) begin
          if (delay < 0) begin
            cur = (fidx < nreq && ord[fidx]) ? ez : em;
            total++; if (fidx >= nreq || rom_addr !== cur) begin bad++; $display("FAIL rnd_addr%0d: got %h want %h (fetch %0d of %0d)", it, rom_addr, cur, fidx, nreq); end
            fidx++;
            delay = $urandom_range(0, 3);
          end else begin
            total++; if (rom_addr !== cur) begin bad++; $display("FAIL rnd_hold%0d: got %h want %h", it, rom_addr, cur); end
          end
          if (delay == 0) begin
            rom_ack = 1; rom_data = mem_word(rom_addr); delay = -1;
          end else begin
            delay--;
          end
        end
      end
      total++; if (sidx != nreq) begin bad++; $display("FAIL rnd_timeout%0d: got served=%0d want %0d", it, sidx, nreq); end
      m68k_rom_cs = 0; m68k_rom_2_cs = 0; z80_rom_cs = 0; z80_banked_cs = 0; rom_ack = 0;
      tick();
      total++; if (m68k_ready !== 1'b0 || z80_ready !== 1'b0 || rom_req !== 1'b0) begin
        bad++; $display("FAIL rnd_quiet%0d: got rdy=%b%b req=%b want 00 0", it, m68k_ready, z80_ready, rom_req);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_tie(23'h000010, 16'h1234);
    test_m68k_single();
    test_z80_banked();
    test_tie(23'h01FFFF, 16'h7FFF);
    test_abort();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
